// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// instruction field positions and the buffered fetch entry layout.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO holding fetched {pc, instr} entries; flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small
// FIFO of decoded-field instruction words, with redirect/flush handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [5:0]  out_funct,
  output logic [15:0] out_imm16,
  output state_t      fsm_state
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: imem_req rises with imem_addr and both hold until imem_ack;
  // the word on imem_rdata is taken in the ack cycle and the request retires.

  state_t        state;
  state_t        state_next;
  logic [31:0]   pc;
  logic [31:0]   req_addr;
  logic [CW-1:0] count;
  logic          issue;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign issue = rst_n && (state == IDLE) && !redirect_valid && (count < CW'(DEPTH));

  always_comb begin
    state_next = state;
    push       = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = 32'h0;
    case (state)
      IDLE: begin
        if (issue) begin
          imem_req   = 1'b1;
          imem_addr  = pc;
          state_next = WAIT;
        end
      end
      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
        if (imem_ack) begin
          push       = !redirect_valid;
          state_next = IDLE;
        end else if (redirect_valid) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        // The old request must still complete; its data is thrown away.
        imem_req  = 1'b1;
        imem_addr = req_addr;
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= 32'h0;
    end else begin
      state <= state_next;
      if (issue) req_addr <= pc;
      if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
      else if (push)      pc <= pc + 32'd4;
    end
  end

  assign push_entry.pc    = req_addr;
  assign push_entry.instr = imem_rdata;
  assign pop              = out_valid && !stall && !redirect_valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign out_valid  = (count != '0);
  assign out_instr  = out_valid ? head.instr : 32'h0;
  assign out_pc4    = out_valid ? head.pc + 32'd4 : 32'h0;
  assign out_opcode = out_instr[OPCODE_HI:OPCODE_LO];
  assign out_rs     = out_instr[RS_HI:RS_LO];
  assign out_rt     = out_instr[RT_HI:RT_LO];
  assign out_rd     = out_instr[RD_HI:RD_LO];
  assign out_funct  = out_instr[FUNCT_HI:FUNCT_LO];
  assign out_imm16  = out_instr[IMM_HI:IMM_LO];
  assign fsm_state  = state;

endmodule
